// File: rtl/av2_loop_filter_sequencer_if.sv
// av2_loop_filter_sequencer_if: frame control, per-stage start/valid/ready and status for the loop-filter sequencer.
interface av2_loop_filter_sequencer_if;
   logic       frame_start;
   logic [7:0] sb_cols_in;
   logic [7:0] sb_rows_in;
   logic       dbk_en;
   logic       cdef_en;
   logic       lr_en;
   logic       dbk_start;
   logic       cdef_start;
   logic       lr_start;
   logic       dbk_valid;
   logic       cdef_valid;
   logic       lr_valid;
   logic       dbk_ready;
   logic       cdef_ready;
   logic       lr_ready;
   logic [7:0] sb_x;
   logic [7:0] sb_y;
   logic       busy;
   logic       frame_done;
   logic       timeout_err;
   modport master (
      input  frame_start, sb_cols_in, sb_rows_in, dbk_en, cdef_en, lr_en,
      input  dbk_valid, cdef_valid, lr_valid,
      output dbk_start, cdef_start, lr_start, dbk_ready, cdef_ready, lr_ready,
      output sb_x, sb_y, busy, frame_done, timeout_err
   );
   modport slave (
      output frame_start, sb_cols_in, sb_rows_in, dbk_en, cdef_en, lr_en,
      output dbk_valid, cdef_valid, lr_valid,
      input  dbk_start, cdef_start, lr_start, dbk_ready, cdef_ready, lr_ready,
      input  sb_x, sb_y, busy, frame_done, timeout_err
   );
endinterface

// File: rtl/av2_loop_filter_sequencer.sv
// av2_loop_filter_sequencer: serial deblock -> CDEF -> LR scheduler over a raster superblock walk,
// with a per-stage watchdog that aborts the frame.
module av2_loop_filter_sequencer #(
   parameter int MAX_SB_COLS    = 16,
   parameter int MAX_SB_ROWS    = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input logic                          clk,
   input logic                          rst_n,
   av2_loop_filter_sequencer_if.master  bus
);
   localparam int              CW      = $clog2(TIMEOUT_CYCLES);
   localparam logic [7:0]      MAX_C   = 8'(MAX_SB_COLS);
   localparam logic [7:0]      MAX_R   = 8'(MAX_SB_ROWS);
   localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
   typedef enum logic [3:0] {IDLE, DBK_S, DBK_W, CDEF_S, CDEF_W, LR_S, LR_W, NEXT_SB, DONE} state_t;
   state_t        state_q, state_d, first_in, first_q, after_dbk, after_cdef;
   logic [7:0]    cols_q, cols_d, rows_q, rows_d, sb_x_q, sb_x_d, sb_y_q, sb_y_d, cols_in, rows_in;
   logic [2:0]    en_q, en_d, en_in;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          terr_q, terr_d;
   logic          accept, in_w, w_valid, timeout, col_end, last_sb;
   always_comb begin
      accept     = state_q == IDLE && bus.frame_start;
      cols_in    = bus.sb_cols_in > MAX_C ? MAX_C : bus.sb_cols_in;
      rows_in    = bus.sb_rows_in > MAX_R ? MAX_R : bus.sb_rows_in;
      en_in      = {bus.lr_en, bus.cdef_en, bus.dbk_en};
      in_w       = state_q inside {DBK_W, CDEF_W, LR_W};
      w_valid    = (state_q == DBK_W && bus.dbk_valid) || (state_q == CDEF_W && bus.cdef_valid) ||
                   (state_q == LR_W && bus.lr_valid);
      timeout    = in_w && !w_valid && cnt_q == CNT_MAX;
      col_end    = sb_x_q == cols_q - 8'd1;
      last_sb    = col_end && sb_y_q == rows_q - 8'd1;
      first_in   = en_in[0] ? DBK_S : en_in[1] ? CDEF_S : en_in[2] ? LR_S : NEXT_SB;
      first_q    = en_q[0] ? DBK_S : en_q[1] ? CDEF_S : en_q[2] ? LR_S : NEXT_SB;
      after_dbk  = en_q[1] ? CDEF_S : en_q[2] ? LR_S : NEXT_SB;
      after_cdef = en_q[2] ? LR_S : NEXT_SB;
   end
   // Position advances only on non-final superblocks so the last position is held at DONE.
   always_comb begin
      cols_d = accept ? cols_in : cols_q;
      rows_d = accept ? rows_in : rows_q;
      en_d   = accept ? en_in : en_q;
      sb_x_d = accept ? 8'd0 : (state_q == NEXT_SB && !last_sb) ? (col_end ? 8'd0 : sb_x_q + 8'd1) : sb_x_q;
      sb_y_d = accept ? 8'd0 : (state_q == NEXT_SB && !last_sb && col_end) ? sb_y_q + 8'd1 : sb_y_q;
      cnt_d  = (in_w && !w_valid) ? (cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1) : '0;
      terr_d = accept ? 1'b0 : (timeout | terr_q);
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = (cols_in == 8'd0 || rows_in == 8'd0) ? DONE : first_in;
         DBK_S:   state_d = DBK_W;
         DBK_W:   state_d = bus.dbk_valid ? after_dbk : timeout ? DONE : DBK_W;
         CDEF_S:  state_d = CDEF_W;
         CDEF_W:  state_d = bus.cdef_valid ? after_cdef : timeout ? DONE : CDEF_W;
         LR_S:    state_d = LR_W;
         LR_W:    state_d = bus.lr_valid ? NEXT_SB : timeout ? DONE : LR_W;
         NEXT_SB: state_d = last_sb ? DONE : first_q;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cols_q  <= '0;
         rows_q  <= '0;
         en_q    <= '0;
         sb_x_q  <= '0;
         sb_y_q  <= '0;
         cnt_q   <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cols_q  <= cols_d;
         rows_q  <= rows_d;
         en_q    <= en_d;
         sb_x_q  <= sb_x_d;
         sb_y_q  <= sb_y_d;
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
      end
   end
   always_comb begin
      bus.dbk_start   = state_q == DBK_S;
      bus.cdef_start  = state_q == CDEF_S;
      bus.lr_start    = state_q == LR_S;
      bus.dbk_ready   = state_q == DBK_W;
      bus.cdef_ready  = state_q == CDEF_W;
      bus.lr_ready    = state_q == LR_W;
      bus.busy        = state_q != IDLE;
      bus.frame_done  = state_q == DONE;
      bus.sb_x        = sb_x_q;
      bus.sb_y        = sb_y_q;
      bus.timeout_err = terr_q;
   end
endmodule

// File: tb/tb_av2_loop_filter_sequencer.sv
// tb_av2_loop_filter_sequencer: directed scenarios with hand-computed cycle counts;
// each stage is modelled as a responder that raises valid a fixed delay after its start.
module tb_av2_loop_filter_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   av2_loop_filter_sequencer_if bus ();
   av2_loop_filter_sequencer #(.MAX_SB_COLS(16), .MAX_SB_ROWS(16), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   int compared = 0;
   int mismatched = 0;
   int dly[3];
   int rcnt[3];
   bit hs[3];
   logic [2:0] vld = 3'b000;
   int nstart[3];
   int nfd;
   int order[$];
   logic [2:0] st, rd;
   assign bus.dbk_valid  = vld[0];
   assign bus.cdef_valid = vld[1];
   assign bus.lr_valid   = vld[2];
   assign st = {bus.lr_start, bus.cdef_start, bus.dbk_start};
   assign rd = {bus.lr_ready, bus.cdef_ready, bus.dbk_ready};
   // Delay 0 means the stage never answers.
   always @(negedge clk) begin
      if (!rst_n || !bus.busy) begin
         vld = 3'b000;
         for (int i = 0; i < 3; i++) begin
            rcnt[i] = 0;
            hs[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (hs[i]) vld[i] = 1'b0;
            if (st[i]) rcnt[i] = dly[i];
            else if (rcnt[i] > 0) begin
               rcnt[i]--;
               if (rcnt[i] == 0) vld[i] = 1'b1;
            end
            hs[i] = vld[i] && rd[i];
         end
      end
   end
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 3; i++) if (st[i]) begin
            nstart[i]++;
            order.push_back(i);
         end
         if (bus.frame_done) nfd++;
      end
   end
   task automatic launch(input logic [7:0] c, input logic [7:0] r, input logic [2:0] en);
      for (int i = 0; i < 3; i++) nstart[i] = 0;
      nfd = 0;
      order.delete();
      bus.sb_cols_in = c;
      bus.sb_rows_in = r;
      {bus.lr_en, bus.cdef_en, bus.dbk_en} = en;
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
   endtask
   task automatic wait_done(input int budget, output int cyc);
      cyc = 1;
      while (!bus.frame_done && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      compared++;
      if (bus.frame_done !== 1'b1) begin
         mismatched++;
         $display("FAIL done_wait: frame_done not seen within %0d cycles", budget);
      end
   endtask
   task automatic test_reset;
      @(negedge clk);
      compared++;
      if ({bus.busy, bus.frame_done, bus.timeout_err} !== 3'b000) begin
         mismatched++;
         $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.frame_done, bus.timeout_err});
      end
      compared++;
      if ({st, rd} !== 6'b0) begin
         mismatched++;
         $display("FAIL reset_handshake: got %b want 000000", {st, rd});
      end
      compared++;
      if ({bus.sb_x, bus.sb_y} !== 16'h0) begin
         mismatched++;
         $display("FAIL reset_pos: got %h want 0000", {bus.sb_x, bus.sb_y});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask
   task automatic test_all_stages;
      int cyc;
      dly = '{3, 3, 3};
      launch(8'd1, 8'd1, 3'b111);
      wait_done(40, cyc);
      compared++;
      if (cyc !== 14) begin
         mismatched++;
         $display("FAIL all_done_cycle: got %0d want 14", cyc);
      end
      compared++;
      if (bus.busy !== 1'b1) begin
         mismatched++;
         $display("FAIL all_busy_at_done: got %b want 1", bus.busy);
      end
      @(negedge clk);
      compared++;
      if (bus.busy !== 1'b0) begin
         mismatched++;
         $display("FAIL all_busy_after: got %b want 0", bus.busy);
      end
      for (int i = 0; i < 3; i++) begin
         compared++;
         if (nstart[i] !== 1) begin
            mismatched++;
            $display("FAIL all_start_count[%0d]: got %0d want 1", i, nstart[i]);
         end
      end
      compared++;
      if (order.size() !== 3) begin
         mismatched++;
         $display("FAIL all_order_len: got %0d want 3", order.size());
      end
      for (int i = 0; i < order.size(); i++) begin
         compared++;
         if (order[i] !== i) begin
            mismatched++;
            $display("FAIL all_order[%0d]: got %0d want %0d", i, order[i], i);
         end
      end
      compared++;
      if (nfd !== 1) begin
         mismatched++;
         $display("FAIL all_frame_done_count: got %0d want 1", nfd);
      end
   endtask
   task automatic test_no_stages;
      logic [7:0] ex[4] = '{8'd0, 8'd1, 8'd0, 8'd1};
      logic [7:0] ey[4] = '{8'd0, 8'd0, 8'd1, 8'd1};
      launch(8'd2, 8'd2, 3'b000);
      for (int c = 0; c < 4; c++) begin
         compared++;
         if ({bus.sb_x, bus.sb_y, bus.frame_done} !== {ex[c], ey[c], 1'b0}) begin
            mismatched++;
            $display("FAIL none_walk cycle %0d: got x=%0d y=%0d done=%b want x=%0d y=%0d done=0",
                     c + 1, bus.sb_x, bus.sb_y, bus.frame_done, ex[c], ey[c]);
         end
         @(negedge clk);
      end
      compared++;
      if (bus.frame_done !== 1'b1) begin
         mismatched++;
         $display("FAIL none_done_cycle5: got %b want 1", bus.frame_done);
      end
      @(negedge clk);
      compared++;
      if (nstart[0] + nstart[1] + nstart[2] !== 0) begin
         mismatched++;
         $display("FAIL none_starts: got %0d want 0", nstart[0] + nstart[1] + nstart[2]);
      end
   endtask
   task automatic test_skip_cdef;
      int cyc;
      dly = '{3, 3, 3};
      launch(8'd3, 8'd1, 3'b101);
      wait_done(60, cyc);
      compared++;
      if (cyc !== 28) begin
         mismatched++;
         $display("FAIL skip_done_cycle: got %0d want 28", cyc);
      end
      compared++;
      if ({bus.sb_x, bus.sb_y} !== {8'd2, 8'd0}) begin
         mismatched++;
         $display("FAIL skip_pos: got x=%0d y=%0d want x=2 y=0", bus.sb_x, bus.sb_y);
      end
      @(negedge clk);
      compared++;
      if ({nstart[0], nstart[1], nstart[2]} !== {32'd3, 32'd0, 32'd3}) begin
         mismatched++;
         $display("FAIL skip_starts: got %0d/%0d/%0d want 3/0/3", nstart[0], nstart[1], nstart[2]);
      end
   endtask
   task automatic test_timeout;
      int cyc;
      dly = '{3, 0, 3};
      launch(8'd1, 8'd1, 3'b111);
      wait_done(60, cyc);
      compared++;
      if (cyc !== 22) begin
         mismatched++;
         $display("FAIL to_done_cycle: got %0d want 22", cyc);
      end
      compared++;
      if (bus.timeout_err !== 1'b1) begin
         mismatched++;
         $display("FAIL to_err_at_done: got %b want 1", bus.timeout_err);
      end
      @(negedge clk);
      compared++;
      if (bus.timeout_err !== 1'b1) begin
         mismatched++;
         $display("FAIL to_err_sticky: got %b want 1", bus.timeout_err);
      end
      compared++;
      if ({nstart[2], nfd} !== {32'd0, 32'd1}) begin
         mismatched++;
         $display("FAIL to_lr_and_done: got lr=%0d done=%0d want lr=0 done=1", nstart[2], nfd);
      end
      dly = '{3, 3, 3};
      launch(8'd1, 8'd1, 3'b000);
      compared++;
      if (bus.timeout_err !== 1'b0) begin
         mismatched++;
         $display("FAIL to_err_cleared: got %b want 0", bus.timeout_err);
      end
      wait_done(10, cyc);
      @(negedge clk);
   endtask
   task automatic test_timeout_edge;
      int cyc;
      for (int d = 16; d <= 17; d++) begin
         dly = '{3, d, 3};
         launch(8'd1, 8'd1, 3'b010);
         wait_done(40, cyc);
         compared++;
         if (cyc !== (d == 16 ? 19 : 18)) begin
            mismatched++;
            $display("FAIL edge_done_cycle d=%0d: got %0d want %0d", d, cyc, d == 16 ? 19 : 18);
         end
         compared++;
         if (bus.timeout_err !== (d == 17)) begin
            mismatched++;
            $display("FAIL edge_err d=%0d: got %b want %b", d, bus.timeout_err, d == 17);
         end
         @(negedge clk);
      end
   endtask
   task automatic test_clamp_and_zero;
      int cyc;
      launch(8'd40, 8'd1, 3'b000);
      wait_done(40, cyc);
      compared++;
      if ({cyc[7:0], bus.sb_x, bus.sb_y} !== {8'd17, 8'd15, 8'd0}) begin
         mismatched++;
         $display("FAIL clamp_cols: got cyc=%0d x=%0d y=%0d want cyc=17 x=15 y=0", cyc, bus.sb_x, bus.sb_y);
      end
      @(negedge clk);
      launch(8'd1, 8'd200, 3'b000);
      wait_done(40, cyc);
      compared++;
      if ({cyc[7:0], bus.sb_x, bus.sb_y} !== {8'd17, 8'd0, 8'd15}) begin
         mismatched++;
         $display("FAIL clamp_rows: got cyc=%0d x=%0d y=%0d want cyc=17 x=0 y=15", cyc, bus.sb_x, bus.sb_y);
      end
      @(negedge clk);
      launch(8'd0, 8'd5, 3'b111);
      compared++;
      if (bus.frame_done !== 1'b1) begin
         mismatched++;
         $display("FAIL zero_cols_done: got %b want 1", bus.frame_done);
      end
      @(negedge clk);
      launch(8'd3, 8'd0, 3'b111);
      compared++;
      if (bus.frame_done !== 1'b1) begin
         mismatched++;
         $display("FAIL zero_rows_done: got %b want 1", bus.frame_done);
      end
      @(negedge clk);
      compared++;
      if (nstart[0] + nstart[1] + nstart[2] !== 0) begin
         mismatched++;
         $display("FAIL zero_starts: got %0d want 0", nstart[0] + nstart[1] + nstart[2]);
      end
   endtask
   task automatic test_hold_and_reset;
      int cyc;
      dly = '{3, 3, 3};
      for (int i = 0; i < 3; i++) nstart[i] = 0;
      nfd = 0;
      bus.sb_cols_in = 8'd1;
      bus.sb_rows_in = 8'd1;
      {bus.lr_en, bus.cdef_en, bus.dbk_en} = 3'b111;
      bus.frame_start = 1'b1;
      @(negedge clk);
      wait_done(40, cyc);
      bus.frame_start = 1'b0;
      @(negedge clk);
      compared++;
      if ({cyc, nstart[0], nfd} !== {32'd14, 32'd1, 32'd1}) begin
         mismatched++;
         $display("FAIL hold_single_frame: got cyc=%0d dbk=%0d done=%0d want 14/1/1", cyc, nstart[0], nfd);
      end
      launch(8'd3, 8'd1, 3'b001);
      repeat (6) @(negedge clk);
      compared++;
      if ({bus.dbk_ready, bus.sb_x} !== {1'b1, 8'd1}) begin
         mismatched++;
         $display("FAIL mid_dbk_w: got ready=%b x=%0d want ready=1 x=1", bus.dbk_ready, bus.sb_x);
      end
      rst_n = 1'b0;
      #1;
      compared++;
      if ({bus.busy, bus.frame_done, bus.timeout_err, st, rd, bus.sb_x, bus.sb_y} !== 25'h0) begin
         mismatched++;
         $display("FAIL async_reset_outputs: got %h want 0",
                  {bus.busy, bus.frame_done, bus.timeout_err, st, rd, bus.sb_x, bus.sb_y});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      compared++;
      if ({bus.busy, nfd} !== {1'b0, 32'd0}) begin
         mismatched++;
         $display("FAIL post_reset_idle: got busy=%b done=%0d want 0/0", bus.busy, nfd);
      end
   endtask
   initial begin
      #500000;
      $display("FAIL global_watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      bus.frame_start = 1'b0;
      bus.sb_cols_in = 8'd0;
      bus.sb_rows_in = 8'd0;
      {bus.lr_en, bus.cdef_en, bus.dbk_en} = 3'b000;
      dly = '{3, 3, 3};
      for (int i = 0; i < 3; i++) nstart[i] = 0;
      nfd = 0;
      test_reset();
      test_all_stages();
      test_no_stages();
      test_skip_cdef();
      test_timeout();
      test_timeout_edge();
      test_clamp_and_zero();
      test_hold_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
